evp_fsm_3: RTL

EVP_FSM_3 -- requirements
Module: evp_fsm_3

---
 rtl/evp_fsm_3.sv | 133 +++++++++++++
 1 files changed

// File: rtl/evp_fsm_3.sv
`timescale 1ns/1ps
// Polynomial evaluation sequencer: reads the degree of a coefficient vector, then walks
// its coefficients highest degree first and accumulates with Horner's rule. It ends by
// writing a result/status pair to the result and status FIFOs.
module evp_fsm_3 #(
  parameter int unsigned word_size = 16,
  parameter int unsigned n_size    = 8,
  parameter int unsigned max_deg   = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_evp,
  input  logic [$clog2(n_size)-1:0]      A,
  input  logic [word_size-1:0]           x,
  input  logic [4:0]                     N_in,
  input  logic [word_size-1:0]           c_in,
  output logic                           en_rd_N,
  output logic [$clog2(n_size)-1:0]      rd_addr_N,
  output logic                           en_rd_S,
  output logic [$clog2(n_size)-1:0]      rd_addr_S_vec,
  output logic [$clog2(max_deg+1)-1:0]   rd_addr_S_coef,
  output logic [31:0]                    result,
  output logic [31:0]                    status,
  output logic                           fifo_wr_en_r,
  output logic                           fifo_wr_en_s,
  output logic                           done_evp
);

  localparam int unsigned AddrW = $clog2(n_size);
  localparam int unsigned CoefW = $clog2(max_deg + 1);
  localparam logic [4:0]  MaxDeg = 5'(max_deg);

  typedef enum logic [2:0] {
    StIdle,
    StRdN,
    StWaitN,
    StRdCoef,
    StMac,
    StOutput,
    StError,
    StEnd
  } state_e;

  state_e               state_q;
  logic [AddrW-1:0]     a_q;
  logic [word_size-1:0] x_q;
  logic [4:0]           k_q;
  logic [31:0]          acc_q;
  logic [31:0]          mac_val;

  // One Horner step; the product is truncated to 32 bits so overflow simply wraps.
  assign mac_val = acc_q * 32'(x_q) + 32'(c_in);

  // Sequencer state, operand latches, accumulator and the result/status registers.
  // result/status are loaded on entry to OUTPUT/ERROR so they are valid alongside the strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      x_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      result  <= '0;
      status  <= 32'hFFFF_FFFF;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_evp) begin
            a_q     <= A;
            x_q     <= x;
            state_q <= StRdN;
          end
        end
        StRdN: state_q <= StWaitN;
        StWaitN: begin
          k_q <= N_in;
          if (N_in > MaxDeg) begin
            result  <= '0;
            status  <= 32'd1;
            state_q <= StError;
          end else begin
            acc_q   <= '0;
            state_q <= StRdCoef;
          end
        end
        StRdCoef: state_q <= StMac;
        StMac: begin
          acc_q <= mac_val;
          if (k_q == 5'd0) begin
            result  <= mac_val;
            status  <= 32'd0;
            state_q <= StOutput;
          end else begin
            k_q     <= k_q - 5'd1;
            state_q <= StRdCoef;
          end
        end
        StOutput: state_q <= StEnd;
        StError:  state_q <= StEnd;
        StEnd:    state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Enables, strobes and done are pure decodes of the state register.
  always_comb begin
    en_rd_N      = 1'b0;
    en_rd_S      = 1'b0;
    fifo_wr_en_r = 1'b0;
    fifo_wr_en_s = 1'b0;
    done_evp     = 1'b0;
    unique case (state_q)
      StRdN:    en_rd_N = 1'b1;
      StRdCoef: en_rd_S = 1'b1;
      StOutput: begin
        fifo_wr_en_r = 1'b1;
        fifo_wr_en_s = 1'b1;
      end
      StError:  fifo_wr_en_s = 1'b1;
      StEnd:    done_evp = 1'b1;
      default:  ;
    endcase
  end

  // Addresses track the latched operands; both are zero out of reset.
  always_comb begin
    rd_addr_N      = a_q;
    rd_addr_S_vec  = a_q;
    rd_addr_S_coef = k_q[CoefW-1:0];
  end

endmodule
